// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
//  Module   : multi_timer
//  Brief    : NCH independent loadable down-stream timers sharing a single
//             time-unit enable. Each channel counts up from zero on en_i ticks
//             and pulses done_o when its count equals its captured target.
//             Optional auto-reload (periodic) mode per channel.
//  Options  : MULTI_TIMER_PERIODIC_EN - when defined, each channel carries a
//             mode register sampled from periodic_i at start; when undefined,
//             periodic_i is ignored and every channel is one-shot.
//  Revision : 1.0 - initial multi-channel release
// ============================================================================
module multi_timer #(
  parameter int DW  = 16,
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [NCH-1:0]    start_i,
  input  logic [NCH-1:0]    clr_i,
  input  logic [NCH-1:0]    periodic_i,
  input  logic [NCH*DW-1:0] target_i,
  output logic [NCH-1:0]    done_o,
  output logic [NCH-1:0]    active_o,
  output logic [NCH*DW-1:0] count_o,
  output logic              any_done_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

`ifndef MULTI_TIMER_PERIODIC_EN
  // Without auto-reload support the mode input has no consumer.
  logic w_unused_periodic;
  assign w_unused_periodic = ^periodic_i;
`endif

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      state_e        state_q;
      logic [DW-1:0] count_q;
      logic [DW-1:0] target_q;
      logic          w_reached;
      logic          w_mode;

      // Expiry is purely a function of the registered state, so done_o is
      // visible in the same cycle the count lands on the target.
      assign w_reached = (state_q == ST_ACTIVE) && (count_q == target_q);

`ifdef MULTI_TIMER_PERIODIC_EN
      logic mode_q;

      // Mode is latched only on a start that is not overridden by a clear.
      always_ff @(posedge clk) begin
        if (rst) begin
          mode_q <= 1'b0;
        end else if (!clr_i[c] && start_i[c]) begin
          mode_q <= periodic_i[c];
        end
      end

      assign w_mode = mode_q;
`else
      assign w_mode = 1'b0;
`endif

      // Channel FSM: clear beats start beats expiry beats tick.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q  <= ST_IDLE;
          count_q  <= '0;
          target_q <= '0;
        end else if (clr_i[c]) begin
          // Abort keeps count and target visible for post-mortem reads.
          state_q <= ST_IDLE;
        end else if (start_i[c]) begin
          state_q  <= ST_ACTIVE;
          count_q  <= '0;
          target_q <= target_i[c*DW +: DW];
        end else if (w_reached) begin
          if (w_mode) begin
            // Reload consumes this cycle; a coincident tick is dropped,
            // which makes the period T+1 cycles under a continuous enable.
            count_q <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end else if ((state_q == ST_ACTIVE) && en_i) begin
          count_q <= count_q + DW'(1);
        end
      end

      assign done_o[c]              = w_reached;
      assign active_o[c]            = (state_q == ST_ACTIVE);
      assign count_o[c*DW +: DW]    = count_q;
    end
  endgenerate

  assign any_done_o = |done_o;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_timer
//  Brief    : Directed plus random stimulus for multi_timer, checked every
//             cycle against a behavioural per-channel model.
//  Revision : 1.0 - initial
// ============================================================================
module tb_multi_timer;
  localparam int DW  = 4;
  localparam int NCH = 4;
`ifdef MULTI_TIMER_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              en_i;
  logic [NCH-1:0]    start_i;
  logic [NCH-1:0]    clr_i;
  logic [NCH-1:0]    periodic_i;
  logic [NCH*DW-1:0] target_i;
  logic [NCH-1:0]    done_o;
  logic [NCH-1:0]    active_o;
  logic [NCH*DW-1:0] count_o;
  logic              any_done_o;

  multi_timer #(.DW(DW), .NCH(NCH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .start_i    (start_i),
    .clr_i      (clr_i),
    .periodic_i (periodic_i),
    .target_i   (target_i),
    .done_o     (done_o),
    .active_o   (active_o),
    .count_o    (count_o),
    .any_done_o (any_done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: one record per channel, plain integers.
  int m_act  [NCH];
  int m_cnt  [NCH];
  int m_tgt  [NCH];
  int m_mode [NCH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 0; m_cnt[c] = 0; m_tgt[c] = 0; m_mode[c] = 0;
    end
  endtask

  // Apply one clock edge worth of the rules to the model.
  task automatic model_step(input logic en, input logic [NCH-1:0] st, input logic [NCH-1:0] cl,
                            input logic [NCH-1:0] pe, input logic [NCH*DW-1:0] tg);
    for (int c = 0; c < NCH; c++) begin
      int reached;
      reached = (m_act[c] != 0) && (m_cnt[c] == m_tgt[c]);
      if (cl[c]) begin
        m_act[c] = 0;
      end else if (st[c]) begin
        m_act[c]  = 1;
        m_cnt[c]  = 0;
        m_tgt[c]  = int'(tg[c*DW +: DW]);
        m_mode[c] = PER_EN ? int'(pe[c]) : 0;
      end else if (reached != 0) begin
        if (m_mode[c] != 0) m_cnt[c] = 0;
        else                m_act[c] = 0;
      end else if (m_act[c] != 0 && en) begin
        m_cnt[c] = (m_cnt[c] + 1) % (1 << DW);
      end
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0]    ed;
    logic [NCH-1:0]    ea;
    logic [NCH*DW-1:0] ec;
    for (int c = 0; c < NCH; c++) begin
      ea[c] = (m_act[c] != 0);
      ed[c] = (m_act[c] != 0) && (m_cnt[c] == m_tgt[c]);
      ec[c*DW +: DW] = DW'(m_cnt[c]);
    end
    check("done_o",     64'(done_o),     64'(ed));
    check("active_o",   64'(active_o),   64'(ea));
    check("count_o",    64'(count_o),    64'(ec));
    check("any_done_o", 64'(any_done_o), 64'(|ed));
  endtask

  // Drive one cycle of inputs, take the edge, then compare everything.
  task automatic cyc(input logic en, input logic [NCH-1:0] st, input logic [NCH-1:0] cl,
                     input logic [NCH-1:0] pe, input logic [NCH*DW-1:0] tg);
    en_i = en; start_i = st; clr_i = cl; periodic_i = pe; target_i = tg;
    @(posedge clk);
    model_step(en, st, cl, pe, tg);
    #1;
    check_all();
  endtask

  initial begin
    logic [NCH*DW-1:0] tg;
    logic [NCH-1:0]    st, cl, pe;

    // ---- reset then idle ----
    rst = 1'b1; en_i = 1'b0; start_i = '0; clr_i = '0; periodic_i = '0; target_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_done",   64'(done_o),     64'(0));
    check("rst_active", 64'(active_o),   64'(0));
    check("rst_count",  64'(count_o),    64'(0));
    check("rst_any",    64'(any_done_o), 64'(0));
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, '0, '0, '0);
    check("idle_count", 64'(count_o), 64'(0));

    // ---- one-shot ch0 T=5, continuous enable ----
    tg = '0; tg[0*DW +: DW] = 4'd5;
    cyc(1'b1, 4'b0001, '0, '0, tg);
    for (int k = 1; k <= 8; k++) begin
      check("os_done0",   64'(done_o[0]),   64'(k == 6));
      check("os_active0", 64'(active_o[0]), 64'(k <= 6));
      if (k >= 6) check("os_hold0", 64'(count_o[0*DW +: DW]), 64'(5));
      cyc(1'b1, '0, '0, '0, '0);
    end

    // ---- periodic ch1 T=3 ----
    tg = '0; tg[1*DW +: DW] = 4'd3;
    cyc(1'b1, 4'b0010, '0, 4'b0010, tg);
    for (int k = 1; k <= 13; k++) begin
      check("per_done1", 64'(done_o[1]), 64'(PER_EN ? (k % 4 == 0) : (k == 4)));
      cyc(1'b1, '0, '0, '0, 4'hF << (1*DW));
    end
    cyc(1'b0, '0, 4'b1111, '0, '0);
    check("clr_all", 64'(active_o), 64'(0));

    // ---- restart ch2: T=10 then T=2 in cycle 4 ----
    tg = '0; tg[2*DW +: DW] = 4'd10;
    cyc(1'b1, 4'b0100, '0, '0, tg);
    for (int k = 1; k <= 12; k++) begin
      check("rs_done2", 64'(done_o[2]), 64'(k == 7));
      tg = '0; tg[2*DW +: DW] = 4'd2;
      cyc(1'b1, (k == 4) ? 4'b0100 : 4'b0000, '0, '0, tg);
    end
    // clear and start together while active
    tg = '0; tg[2*DW +: DW] = 4'd5;
    cyc(1'b1, 4'b0100, '0, '0, tg);
    cyc(1'b1, 4'b0100, 4'b0100, '0, tg);
    check("cs_active2", 64'(active_o[2]), 64'(0));
    check("cs_done2",   64'(done_o[2]),   64'(0));
    for (int k = 0; k < 6; k++) cyc(1'b1, '0, '0, '0, '0);
    check("cs_idle2", 64'(active_o[2]), 64'(0));

    // ---- ch0 T=0 and ch3 T=15 with enable on odd cycles ----
    tg = '0; tg[0*DW +: DW] = 4'd0; tg[3*DW +: DW] = 4'd15;
    cyc(1'b0, 4'b1001, '0, '0, tg);
    for (int k = 1; k <= 32; k++) begin
      check("gap_done0", 64'(done_o[0]), 64'(k == 1));
      check("gap_done3", 64'(done_o[3]), 64'(k == 30));
      cyc(k[0], '0, '0, '0, '0);
    end

    // ---- random phase ----
    for (int i = 0; i < 600; i++) begin
      st = '0; cl = '0; pe = '0; tg = '0;
      for (int c = 0; c < NCH; c++) begin
        st[c] = ($urandom % 12 == 0);
        cl[c] = ($urandom % 30 == 0);
        pe[c] = $urandom % 2;
        tg[c*DW +: DW] = ($urandom % 8 == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      end
      cyc(($urandom % 3) != 0, st, cl, pe, tg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
